// File: rtl/nunchuck_poller_if.sv
// Command/response bundle between the nunchuck poller and a byte-oriented I2C master.
// Latency: pure wiring, no storage.
// Backpressure: the master throttles the poller through i2c_done (start/done handshake).
interface nunchuck_poller_if;
  logic            i2c_start;
  logic            i2c_write_d;
  logic [6:0]      i2c_deviceAddr_d;
  logic [7:0]      i2c_regAddr_d;
  logic [2:0]      i2c_numBytes_d;
  logic [5:0][7:0] i2c_dataIn_d;
  logic            i2c_driverDisable;
  logic            i2c_done;
  logic [5:0][7:0] i2c_dataOut;

  // Poller side: issues commands, observes completion and read data.
  modport master (
    output i2c_start, i2c_write_d, i2c_deviceAddr_d, i2c_regAddr_d,
           i2c_numBytes_d, i2c_dataIn_d, i2c_driverDisable,
    input  i2c_done, i2c_dataOut
  );

  // I2C master side: accepts commands, reports completion and read data.
  modport slave (
    input  i2c_start, i2c_write_d, i2c_deviceAddr_d, i2c_regAddr_d,
           i2c_numBytes_d, i2c_dataIn_d, i2c_driverDisable,
    output i2c_done, i2c_dataOut
  );
endinterface

// File: rtl/nunchuck_poller.sv
// Initialises a Wii nunchuck over I2C, then periodically polls and decodes its 6-byte report.
// Latency: sample outputs and sampleValid appear one cycle after the read completes (DECODE cycle).
// Backpressure: each command waits for i2c_done high before starting and for done high again to finish.
module nunchuck_poller #(
  parameter int STARTUP_DELAY = 100,
  parameter int POLL_DELAY    = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  nunchuck_poller_if.master        i2c,
  output logic [7:0]               stickX,
  output logic [7:0]               stickY,
  output logic [9:0]               accelX,
  output logic [9:0]               accelY,
  output logic [9:0]               accelZ,
  output logic                     buttonC,
  output logic                     buttonZ,
  output logic                     initDone,
  output logic                     sampleValid
);

  // One shared counter serves both delays; it never exceeds the larger delay minus one.
  localparam int CNT_MAX = (STARTUP_DELAY > POLL_DELAY) ? STARTUP_DELAY : POLL_DELAY;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_DELAY - 1);
  localparam logic [CW-1:0] POLL_LAST    = CW'(POLL_DELAY - 1);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_INIT1, ST_INIT2, ST_POLL_WAIT, ST_REQ, ST_READ, ST_DECODE
  } state_e;

  typedef enum logic [1:0] {
    PH_ISSUE, PH_ACCEPT, PH_BUSY
  } phase_e;

  state_e          r_state, w_nxt_state;
  phase_e          r_phase, w_nxt_phase;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;

  logic            w_in_cmd;
  logic            w_cmd_done;

  logic [5:0][7:0] r_bytes;
  logic [6:0]      r_dev_addr;
  logic            r_drv_dis;
  logic            r_init_done;
  logic            r_sample_vld;
  logic [7:0]      r_stick_x, r_stick_y;
  logic [9:0]      r_accel_x, r_accel_y, r_accel_z;
  logic            r_button_c, r_button_z;

  assign w_in_cmd   = (r_state == ST_INIT1) || (r_state == ST_INIT2) ||
                      (r_state == ST_REQ)   || (r_state == ST_READ);
  // Completion is only honoured while enabled, so a dropped enable abandons the command cleanly.
  assign w_cmd_done = w_in_cmd && (r_phase == PH_BUSY) && i2c.i2c_done && enable;

  // State register: sequencer state, handshake phase and delay counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_STARTUP;
      r_phase <= PH_ISSUE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_phase <= w_nxt_phase;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Next-state logic: delays, command handshake progression and the enable override.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_cnt   = r_cnt;
    if (!enable) begin
      w_nxt_state = ST_STARTUP;
      w_nxt_phase = PH_ISSUE;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        ST_STARTUP: begin
          if (r_cnt == STARTUP_LAST) begin
            w_nxt_state = ST_INIT1;
            w_nxt_phase = PH_ISSUE;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CW'(1);
          end
        end
        ST_POLL_WAIT: begin
          if (r_cnt == POLL_LAST) begin
            w_nxt_state = ST_REQ;
            w_nxt_phase = PH_ISSUE;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + CW'(1);
          end
        end
        ST_DECODE: begin
          w_nxt_state = ST_POLL_WAIT;
          w_nxt_phase = PH_ISSUE;
          w_nxt_cnt   = '0;
        end
        default: begin
          // Command states share one handshake: wait idle, hold start until taken, wait done.
          case (r_phase)
            PH_ISSUE:  if (i2c.i2c_done)  w_nxt_phase = PH_ACCEPT;
            PH_ACCEPT: if (!i2c.i2c_done) w_nxt_phase = PH_BUSY;
            default: begin
              if (i2c.i2c_done) begin
                w_nxt_phase = PH_ISSUE;
                w_nxt_cnt   = '0;
                case (r_state)
                  ST_INIT1: w_nxt_state = ST_INIT2;
                  ST_INIT2: w_nxt_state = ST_POLL_WAIT;
                  ST_REQ:   w_nxt_state = ST_READ;
                  default:  w_nxt_state = ST_DECODE;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  // Output logic: command fields decoded from state so they stay stable for the whole command.
  always_comb begin
    i2c.i2c_start      = w_in_cmd && (r_phase == PH_ACCEPT) && enable;
    i2c.i2c_write_d    = 1'b0;
    i2c.i2c_regAddr_d  = 8'h00;
    i2c.i2c_numBytes_d = 3'd0;
    i2c.i2c_dataIn_d   = '0;
    case (r_state)
      ST_INIT1: begin
        i2c.i2c_write_d     = 1'b1;
        i2c.i2c_regAddr_d   = 8'hF0;
        i2c.i2c_numBytes_d  = 3'd1;
        i2c.i2c_dataIn_d[0] = 8'h55;
      end
      ST_INIT2: begin
        i2c.i2c_write_d     = 1'b1;
        i2c.i2c_regAddr_d   = 8'hFB;
        i2c.i2c_numBytes_d  = 3'd1;
      end
      ST_REQ: begin
        i2c.i2c_write_d     = 1'b1;
      end
      ST_READ: begin
        i2c.i2c_numBytes_d  = 3'd6;
      end
      default: begin
        i2c.i2c_write_d     = 1'b0;
      end
    endcase
  end

  // Datapath: capture read bytes at completion, decode them in DECODE, track init and enable status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bytes      <= '0;
      r_dev_addr   <= 7'h00;
      r_drv_dis    <= 1'b1;
      r_init_done  <= 1'b0;
      r_sample_vld <= 1'b0;
      r_stick_x    <= '0;
      r_stick_y    <= '0;
      r_accel_x    <= '0;
      r_accel_y    <= '0;
      r_accel_z    <= '0;
      r_button_c   <= 1'b0;
      r_button_z   <= 1'b0;
    end else begin
      r_dev_addr   <= 7'h52;
      r_drv_dis    <= ~enable;
      r_sample_vld <= 1'b0;
      if (!enable) begin
        r_init_done <= 1'b0;
      end else if (w_cmd_done && (r_state == ST_INIT2)) begin
        r_init_done <= 1'b1;
      end
      if (w_cmd_done && (r_state == ST_READ)) begin
        r_bytes <= i2c.i2c_dataOut;
      end
      if (enable && (r_state == ST_DECODE)) begin
        r_stick_x    <= r_bytes[0];
        r_stick_y    <= r_bytes[1];
        r_accel_x    <= {r_bytes[2], r_bytes[5][3:2]};
        r_accel_y    <= {r_bytes[3], r_bytes[5][5:4]};
        r_accel_z    <= {r_bytes[4], r_bytes[5][7:6]};
        r_button_z   <= ~r_bytes[5][0];
        r_button_c   <= ~r_bytes[5][1];
        r_sample_vld <= 1'b1;
      end
    end
  end

  assign i2c.i2c_deviceAddr_d  = r_dev_addr;
  assign i2c.i2c_driverDisable = r_drv_dis;
  assign initDone    = r_init_done;
  assign sampleValid = r_sample_vld;
  assign stickX      = r_stick_x;
  assign stickY      = r_stick_y;
  assign accelX      = r_accel_x;
  assign accelY      = r_accel_y;
  assign accelZ      = r_accel_z;
  assign buttonC     = r_button_c;
  assign buttonZ     = r_button_z;

endmodule

// File: tb/tb_nunchuck_poller.sv
// Scoreboard bench: stimulus queues expected commands/samples, an I2C master model and a sample
// monitor pop and compare as the DUT presents them.
// Directed scenarios: init, decode, poll period, handshake hold, enable drop, reset in DECODE.
module tb_nunchuck_poller;
  typedef logic [66:0] cmd_t;
  typedef logic [47:0] smp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic [7:0] stickX, stickY;
  logic [9:0] accelX, accelY, accelZ;
  logic buttonC, buttonZ, initDone, sampleValid;

  nunchuck_poller_if bus ();

  nunchuck_poller #(.STARTUP_DELAY(4), .POLL_DELAY(50)) dut (
    .clk(clk), .rst(rst), .enable(enable), .i2c(bus),
    .stickX(stickX), .stickY(stickY), .accelX(accelX), .accelY(accelY), .accelZ(accelZ),
    .buttonC(buttonC), .buttonZ(buttonZ), .initDone(initDone), .sampleValid(sampleValid)
  );

  always #5 clk = ~clk;

  cmd_t exp_cmd[$];
  smp_t exp_smp[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_sv = -1;
  int en_cyc = -1;
  int smp_seen = 0;
  int accept_hold = 0;
  int busy_len = 20;
  logic [5:0][7:0] rd_bytes;
  logic in_read_busy = 1'b0;
  logic read_completing = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic w, input logic [7:0] r, input logic [2:0] n,
                                  input logic [7:0] d0);
    return {w, 7'h52, r, n, 40'h0, d0};
  endfunction

  function automatic cmd_t cur_cmd();
    return {bus.i2c_write_d, bus.i2c_deviceAddr_d, bus.i2c_regAddr_d, bus.i2c_numBytes_d,
            bus.i2c_dataIn_d};
  endfunction

  function automatic smp_t cur_smp();
    return {stickX, stickY, accelX, accelY, accelZ, buttonC, buttonZ};
  endfunction

  // I2C master model and command monitor.
  initial begin
    cmd_t snap;
    logic is_read;
    bus.i2c_done    = 1'b1;
    bus.i2c_dataOut = {6{8'hEE}};
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.i2c_start === 1'b1) begin
        snap = cur_cmd();
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got %0h expected none", snap);
        end else begin
          check("cmd", 80'(snap), 80'(exp_cmd.pop_front()));
        end
        check("dataIn_upper_zero", 80'(bus.i2c_dataIn_d[5:1]), 80'(0));
        if (snap == mk_cmd(1'b1, 8'hF0, 3'd1, 8'h55)) begin
          last_sv = -1;
          if (en_cyc >= 0) begin
            check("startup_to_init1", 80'(cyc - en_cyc), 80'(5));
            en_cyc = -1;
          end
        end
        if (snap == mk_cmd(1'b1, 8'hFB, 3'd1, 8'h00))
          check("initdone_before_init2", 80'(initDone), 80'(0));
        if (snap == mk_cmd(1'b1, 8'h00, 3'd0, 8'h00) && last_sv >= 0)
          check("poll_period", 80'(cyc - last_sv), 80'(51));
        for (int k = 0; k < accept_hold; k++) begin
          @(negedge clk);
          if (rst === 1'b1 && enable === 1'b1) begin
            check("start_held", 80'(bus.i2c_start), 80'(1));
            check("fields_in_accept", 80'(cur_cmd()), 80'(snap));
          end
        end
        bus.i2c_done = 1'b0;
        is_read = ~snap[66];
        in_read_busy = is_read;
        for (int k = 0; k < busy_len; k++) begin
          @(negedge clk);
          bus.i2c_dataOut = {6{8'(k + 8'hA0)}};
          if (rst === 1'b1 && enable === 1'b1) begin
            check("start_low_busy", 80'(bus.i2c_start), 80'(0));
            check("fields_in_busy", 80'(cur_cmd()), 80'(snap));
          end
        end
        if (is_read) bus.i2c_dataOut = rd_bytes;
        bus.i2c_done = 1'b1;
        in_read_busy = 1'b0;
        read_completing = is_read;
        @(negedge clk);
        bus.i2c_dataOut = {6{8'hEE}};
        read_completing = 1'b0;
      end
    end
  end

  // Sample monitor.
  always @(negedge clk) begin
    if (rst === 1'b1 && sampleValid === 1'b1) begin
      last_sv = cyc;
      smp_seen++;
      if (exp_smp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sample: got %0h expected none", cur_smp());
      end else begin
        check("sample", 80'(cur_smp()), 80'(exp_smp.pop_front()));
      end
    end
  end

  // Stimulus.
  initial begin
    int n;
    rst = 1'b0;
    enable = 1'b1;
    rd_bytes = {8'hB5, 8'hFF, 8'h40, 8'hC0, 8'h7F, 8'h80};
    repeat (3) @(negedge clk);
    check("rst_start", 80'(bus.i2c_start), 80'(0));
    check("rst_write", 80'(bus.i2c_write_d), 80'(0));
    check("rst_reg", 80'(bus.i2c_regAddr_d), 80'(0));
    check("rst_num", 80'(bus.i2c_numBytes_d), 80'(0));
    check("rst_datain", 80'(bus.i2c_dataIn_d), 80'(0));
    check("rst_dev", 80'(bus.i2c_deviceAddr_d), 80'(0));
    check("rst_drvdis", 80'(bus.i2c_driverDisable), 80'(1));
    check("rst_initdone", 80'(initDone), 80'(0));
    check("rst_valid", 80'(sampleValid), 80'(0));
    check("rst_sample", 80'(cur_smp()), 80'(0));

    // Init sequence followed by the first poll.
    exp_cmd.push_back(mk_cmd(1'b1, 8'hF0, 3'd1, 8'h55));
    exp_cmd.push_back(mk_cmd(1'b1, 8'hFB, 3'd1, 8'h00));
    exp_cmd.push_back(mk_cmd(1'b1, 8'h00, 3'd0, 8'h00));
    exp_cmd.push_back(mk_cmd(1'b0, 8'h00, 3'd6, 8'h00));
    exp_smp.push_back({8'h80, 8'h7F, 10'h301, 10'h103, 10'h3FE, 1'b1, 1'b0});
    rst = 1'b1;
    en_cyc = cyc;
    n = 0;
    while (initDone !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("init_done", 80'(initDone), 80'(1));
    check("drvdis_enabled", 80'(bus.i2c_driverDisable), 80'(0));
    n = 0;
    while (smp_seen < 1 && n < 3000) begin @(negedge clk); n++; end
    check("first_sample_seen", 80'(smp_seen), 80'(1));

    // Second poll with a slow accept; poll period is measured from the previous sampleValid.
    accept_hold = 3;
    rd_bytes = {8'h0F, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    exp_cmd.push_back(mk_cmd(1'b1, 8'h00, 3'd0, 8'h00));
    exp_cmd.push_back(mk_cmd(1'b0, 8'h00, 3'd6, 8'h00));
    exp_smp.push_back({8'h12, 8'h34, 10'h15B, 10'h1E0, 10'h268, 1'b0, 1'b0});
    n = 0;
    while (smp_seen < 2 && n < 3000) begin @(negedge clk); n++; end
    check("second_sample_seen", 80'(smp_seen), 80'(2));

    // Third poll: enable drops during the read; nothing may be captured.
    accept_hold = 0;
    rd_bytes = {6{8'hAA}};
    exp_cmd.push_back(mk_cmd(1'b1, 8'h00, 3'd0, 8'h00));
    exp_cmd.push_back(mk_cmd(1'b0, 8'h00, 3'd6, 8'h00));
    n = 0;
    while (in_read_busy !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("in_read_numbytes", 80'(bus.i2c_numBytes_d), 80'(6));
    enable = 1'b0;
    #1;
    check("drop_start", 80'(bus.i2c_start), 80'(0));
    @(negedge clk);
    check("drop_drvdis", 80'(bus.i2c_driverDisable), 80'(1));
    check("drop_initdone", 80'(initDone), 80'(0));
    check("drop_fields", 80'(cur_cmd()), 80'({1'b0, 7'h52, 59'h0}));
    repeat (30) @(negedge clk);
    check("drop_hold_stickx", 80'(stickX), 80'(8'h12));
    check("drop_no_sample", 80'(smp_seen), 80'(2));

    // Re-enable: full init again, then a poll whose DECODE is cut by reset.
    rd_bytes = {6{8'h11}};
    exp_cmd.push_back(mk_cmd(1'b1, 8'hF0, 3'd1, 8'h55));
    exp_cmd.push_back(mk_cmd(1'b1, 8'hFB, 3'd1, 8'h00));
    exp_cmd.push_back(mk_cmd(1'b1, 8'h00, 3'd0, 8'h00));
    exp_cmd.push_back(mk_cmd(1'b0, 8'h00, 3'd6, 8'h00));
    enable = 1'b1;
    en_cyc = cyc;
    n = 0;
    while (read_completing !== 1'b1 && n < 3000) begin @(posedge clk); n++; end
    #2;
    check("decode_valid_low", 80'(sampleValid), 80'(0));
    check("decode_initdone", 80'(initDone), 80'(1));
    rst = 1'b0;
    #1;
    check("arst_sample", 80'(cur_smp()), 80'(0));
    check("arst_initdone", 80'(initDone), 80'(0));
    check("arst_dev", 80'(bus.i2c_deviceAddr_d), 80'(0));
    check("arst_drvdis", 80'(bus.i2c_driverDisable), 80'(1));
    check("arst_fields", 80'({bus.i2c_start, bus.i2c_write_d, bus.i2c_regAddr_d,
                              bus.i2c_numBytes_d, bus.i2c_dataIn_d}), 80'(0));
    repeat (3) @(negedge clk);
    check("arst_no_sample", 80'(smp_seen), 80'(2));

    exp_cmd.push_back(mk_cmd(1'b1, 8'hF0, 3'd1, 8'h55));
    exp_cmd.push_back(mk_cmd(1'b1, 8'hFB, 3'd1, 8'h00));
    rst = 1'b1;
    en_cyc = cyc;
    n = 0;
    while (initDone !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("reinit_done", 80'(initDone), 80'(1));
    repeat (5) @(negedge clk);
    check("cmd_queue_empty", 80'(exp_cmd.size()), 80'(0));
    check("smp_queue_empty", 80'(exp_smp.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/nunchuck_poller.md
NUNCHUCK_POLLER -- requirements
Module: nunchuck_poller

Interface
REQ-001 The module SHALL have parameter STARTUP_DELAY, default 100, meaning clk cycles waited after reset before the first command.
REQ-002 The module SHALL have parameter POLL_DELAY, default 1000, meaning clk cycles from the end of one read to the next request.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is posedge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset (0 = reset).
REQ-005 The module SHALL have port enable, input, 1 bit: run enable.
REQ-006 The module SHALL have port i2c_done, input, 1 bit: I2C master idle/done flag.
REQ-007 The module SHALL have port i2c_dataOut, input, 6x8 bits: read bytes from the master.
REQ-008 The module SHALL have port i2c_start, output, 1 bit: command request.
REQ-009 The module SHALL have port i2c_write_d, output, 1 bit: 1 = write, 0 = read.
REQ-010 The module SHALL have port i2c_deviceAddr_d, output, 7 bits: constant 0x52.
REQ-011 The module SHALL have port i2c_regAddr_d, output, 8 bits: register address.
REQ-012 The module SHALL have port i2c_numBytes_d, output, 3 bits: payload byte count.
REQ-013 The module SHALL have port i2c_dataIn_d, output, 6x8 bits: write payload; only entry 0 is used, entries 1-5 are 0.
REQ-014 The module SHALL have port i2c_driverDisable, output, 1 bit: equal to ~enable, registered.
REQ-015 The module SHALL have output ports stickX and stickY, 8 bits each: joystick position.
REQ-016 The module SHALL have output ports accelX, accelY and accelZ, 10 bits each: accelerometer readings.
REQ-017 The module SHALL have output ports buttonC and buttonZ, 1 bit each: button state, 1 = pressed.
REQ-018 The module SHALL have output port initDone, 1 bit: initialisation writes completed.
REQ-019 The module SHALL have output port sampleValid, 1 bit: one-cycle pulse when the outputs update.

Function
REQ-020 The FSM states SHALL be: STARTUP, INIT1, INIT2, POLL_WAIT, REQ, READ, DECODE.
- INIT1, INIT2, REQ and READ are command states, each with phases ISSUE, ACCEPT and BUSY.
REQ-021 STARTUP SHALL count to STARTUP_DELAY-1, then go to INIT1.
REQ-022 INIT1 SHALL issue a write: regAddr 0xF0, numBytes 1, dataIn[0] 0x55; on completion go to INIT2.
REQ-023 INIT2 SHALL issue a write: regAddr 0xFB, numBytes 1, dataIn[0] 0x00; on completion set initDone=1 and go to POLL_WAIT.
REQ-024 POLL_WAIT SHALL count to POLL_DELAY-1, then go to REQ.
REQ-025 REQ SHALL issue a write: regAddr 0x00, numBytes 0; on completion go to READ.
REQ-026 READ SHALL issue a read: numBytes 6, regAddr 0x00; on completion capture i2c_dataOut[0..5] and go to DECODE.
REQ-027 DECODE SHALL last one cycle, update all sample outputs, pulse sampleValid, and go to POLL_WAIT with its counter cleared.
REQ-028 Command handshake, ISSUE phase: command fields are driven; i2c_start=1 once i2c_done=1 is sampled; go to ACCEPT.
REQ-029 Command handshake, ACCEPT phase: hold i2c_start=1 until i2c_done=0 is sampled, then drop i2c_start and go to BUSY.
REQ-030 Command handshake, BUSY phase: the command completes on the first cycle i2c_done=1 is sampled.
REQ-031 Command fields SHALL remain stable from ISSUE through completion.
REQ-032 Outside a command, command fields SHALL be 0 and i2c_start SHALL be 0.
REQ-033 Decode SHALL map the captured bytes as follows (b0..b5):
- stickX=b0; stickY=b1
- accelX={b2,b5[3:2]}; accelY={b3,b5[5:4]}; accelZ={b4,b5[7:6]}
- buttonZ=~b5[0]; buttonC=~b5[1]
REQ-034 enable=0 SHALL force the FSM to STARTUP with its counter cleared, clear initDone, and drop i2c_start in the same cycle.
- Sample outputs hold their last values.
REQ-035 When enable returns to 1, the module SHALL rerun the full sequence: startup delay, INIT1, INIT2.
REQ-036 If enable falls mid-command, that command SHALL be abandoned, with no data capture and no sampleValid.
REQ-037 i2c_dataOut SHALL be sampled only in the completion cycle of READ; intermediate values are ignored.
REQ-038 Counters SHALL be wide enough for their parameter and SHALL not wrap within a delay.
REQ-039 If i2c_done is already 0 in ISSUE, the module SHALL wait in ISSUE with i2c_start=0.

Reset
REQ-040 While rst=0, the FSM SHALL be in STARTUP with its counter at 0.
REQ-041 While rst=0, these outputs SHALL be 0: i2c_start, i2c_write_d, i2c_regAddr_d, i2c_numBytes_d, i2c_dataIn_d, initDone, sampleValid, stickX, stickY, accelX, accelY, accelZ, buttonC and buttonZ.
REQ-042 While rst=0, i2c_deviceAddr_d SHALL be 0 and i2c_driverDisable SHALL be 1.
REQ-043 Reset release SHALL be synchronised by the first posedge clk with rst=1; operation then begins in STARTUP.
REQ-044 Reset asserted mid-command SHALL immediately apply the reset state above; any sample pending in DECODE is lost.

Verification
REQ-045 Scenario -- init sequence: STARTUP_DELAY=4, master model returns done 20 cycles after start -> exactly two writes, (0xF0,1,0x55) then (0xFB,1,0x00), both to addr 0x52; initDone=1 after the second.
REQ-046 Scenario -- poll/decode: model returns bytes 80,7F,C0,40,FF,B5 -> stickX=0x80, stickY=0x7F, accelX=0x301, accelY=0x103, accelZ=0x3FE, buttonZ=0, buttonC=1, one sampleValid pulse.
REQ-047 Scenario -- poll period: POLL_DELAY=50 -> the REQ i2c_start rise comes exactly 51 cycles after the previous sampleValid.
REQ-048 Scenario -- handshake: hold i2c_done=1 for 3 cycles after start rises -> i2c_start stays 1 for those cycles; fields stay stable until done returns to 1.
REQ-049 Scenario -- enable drop: drop enable during READ BUSY -> i2c_start=0, i2c_driverDisable=1, no sampleValid, initDone=0; on re-enable, INIT1 is reissued after STARTUP_DELAY.
REQ-050 Scenario -- reset during DECODE: pull rst low -> all outputs return to reset values asynchronously; the next init runs after release.
